// File: rtl/io_pkg.sv
// Shared board-I/O constants for the core top, the memory stage and the
// switch conditioning logic.
package io_pkg;

  localparam int SW_WIDTH  = 18;
  localparam int LED_WIDTH = 27;

  localparam int TICK_DIV_DEFAULT     = 50000;
  localparam int STABLE_TICKS_DEFAULT = 4;

  // Qualification counter width; one spare bit so STABLE_TICKS-1 always fits.
  function automatic int stable_count_w(input int stable_ticks);
    return $clog2(stable_ticks) + 1;
  endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Sticky switch-change event channel between the debouncer and its consumer.
interface switch_debouncer_if #(
  parameter int SW_WIDTH = io_pkg::SW_WIDTH
);

  logic                event_valid;
  logic [SW_WIDTH-1:0] event_bits;
  logic                event_ack;

  modport master (output event_valid, output event_bits, input  event_ack);
  modport slave  (input  event_valid, input  event_bits, output event_ack);

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: accepts a new level only after it disagrees with the
// current debounced value for STABLE_TICKS consecutive sample ticks.
module debounce_bit import io_pkg::*; #(
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic sync_bit,
  input  logic tick,
  output logic debounced,
  output logic flip
);

  localparam int CW = stable_count_w(STABLE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          differ;
  logic [CW-1:0] count;

  assign differ = sync_bit ^ debounced;
  assign flip   = differ & tick & (count == LAST);

  // Any agreement, even between ticks, restarts qualification from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      debounced <= 1'b0;
    end else if (!differ) begin
      count <= '0;
    end else if (tick) begin
      if (count == LAST) begin
        count     <= '0;
        debounced <= ~debounced;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Synchronizes and debounces the raw board switches, and reports per-bit
// sticky change flags over a valid/ack event channel.
module switch_debouncer import io_pkg::*; #(
  parameter int SW_WIDTH     = io_pkg::SW_WIDTH,
  parameter int TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches_raw,
  output logic [SW_WIDTH-1:0] switches,
  switch_debouncer_if.master  evt
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [PW-1:0]       prescale;
  logic                tick;
  logic [SW_WIDTH-1:0] flips;
  logic [SW_WIDTH-1:0] next_bits;
  logic                ack_fire;

  // Two-flop synchronizer for the asynchronous board inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switches_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
    end else if (prescale == TICK_LAST) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign tick = (prescale == TICK_LAST);

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clock     (clock),
      .reset     (reset),
      .sync_bit  (sync2[i]),
      .tick      (tick),
      .debounced (switches[i]),
      .flip      (flips[i])
    );
  end

  // An ack clears exactly the flags the consumer saw; a flip landing in the
  // same cycle is ORed in afterwards so it is never lost.
  assign ack_fire = evt.event_ack & evt.event_valid;

  always_comb begin
    next_bits = evt.event_bits;
    if (ack_fire) begin
      next_bits = evt.event_bits & ~evt.event_bits;
    end
    next_bits = next_bits | flips;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      evt.event_bits  <= '0;
      evt.event_valid <= 1'b0;
    end else begin
      evt.event_bits  <= next_bits;
      evt.event_valid <= |next_bits;
    end
  end

endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the 18 raw board switches before they reach the pipelined core's memory-mapped I/O in the memory stage. Each bit passes through a two-flop synchronizer and a tick-based debouncer. Only changes that stay stable for a programmable number of sample ticks are propagated. Per-bit sticky change flags are reported to an event consumer through a valid/ack handshake.

## Interface
- SW_WIDTH, 18, number of switch bits
- TICK_DIV, 50000, clock cycles per sample tick (≥2)
- STABLE_TICKS, 4, consecutive disagreeing ticks required to accept a change (≥1)

- clock  in  1  rising-edge system clock (one clock domain)
- reset  in  1  asynchronous, active-low reset
- switches_raw  in  SW_WIDTH  asynchronous board switch inputs
- switches  out  SW_WIDTH  debounced value; feeds the memory stage's switches input
- event_valid  out  1  high while any bit of event_bits is set
- event_bits  out  SW_WIDTH  sticky per-bit "debounced value changed" flags
- event_ack  in  1  consumer acknowledges the event_bits value seen this cycle

## Operation
- Synchronizer: sync1 <= switches_raw; sync2 <= sync1. Both reset to 0.
- Prescaler: counter runs 0..TICK_DIV-1 and wraps to 0. tick = (counter == TICK_DIV-1). Counter resets to 0.
- Per bit i, with count_i of width clog2(STABLE_TICKS)+1:
  - If sync2[i] == switches[i], count_i <= 0 on every cycle, tick or not. Any bounce back restarts qualification.
  - If they differ, tick is high and count_i < STABLE_TICKS-1: count_i increments.
  - If they differ, tick is high and count_i == STABLE_TICKS-1: switches[i] toggles, count_i <= 0, and event_bits[i] <= 1.
  - If they differ and there is no tick: hold.
- Events:
  - If event_ack && event_valid, the next event_bits = (event_bits & ~event_bits_sampled) | new_flips.
  - A flip of the same bit in the ack cycle sets that bit, so set wins.
  - event_ack while event_valid is low is ignored.
- Reset values:
  - switches = 0, event_bits = 0, event_valid = 0.
  - All counters and sync flops = 0.
  - Switches held high through reset are reported as ordinary debounced changes after qualification.

## Timing
- switches, event_bits and event_valid are registered outputs. There are no combinational input-to-output paths.
- event_valid is driven from the registered event_bits OR-reduction, so it is high in the same cycle event_bits is non-zero.
- Raw change to sync2: 2 cycles.
- sync2 disagreement to output flip: the first STABLE_TICKS ticks at or after the cycle sync2 differs, plus 1 cycle for registration.
- Worst-case latency: 2 + STABLE_TICKS·TICK_DIV cycles. Minimum latency: 2 + (STABLE_TICKS-1)·TICK_DIV + 1 cycles.
- Ticks are at cycle k·TICK_DIV-1 after reset release, for k ≥ 1.
- Ack is single-cycle. A held event_ack clears again each cycle; this is harmless.
- Reset asserted mid-qualification discards partial counts and pending events immediately.

## Structure
- Shared package io_pkg holds:
  - SW_WIDTH = 18 and LED_WIDTH = 27, also used by the core top and the memory stage.
  - The default TICK_DIV / STABLE_TICKS constants.
- Sub-module debounce_bit, generated SW_WIDTH times:
  - Inputs: clock, reset, sync2 bit, tick.
  - Outputs: debounced bit, one-cycle flip pulse.
- Synchronizer, prescaler and event register live in switch_debouncer.
- Expected size: ~150–250 lines.

## Test plan
All scenarios use TICK_DIV=4 and STABLE_TICKS=3, with ticks at cycles 3, 7, 11, 15, 19, 23…

- Reset while switches_raw = 18'h3FFFF:
  - All outputs 0 during reset.
  - After release, switches = 18'h3FFFF from cycle 12.
  - event_bits = 18'h3FFFF and event_valid = 1 from cycle 12.
- Clean change: raw bit 0 set before edge 10.
  - Count advances at ticks 11 and 15 and flips at tick 19.
  - switches[0] = 1 and event_bits = 18'h00001 from cycle 20.
  - Nothing changes before cycle 20.
- Bounce: raw bit 5 high for 6 cycles spanning one tick, then low.
  - switches[5] never changes and event_valid stays 0.
  - Raw then held high resolves after 3 further ticks.
- Ack: event_bits = 18'h00003, event_ack = 1 for 1 cycle.
  - Next cycle event_bits = 0 and event_valid = 0.
  - event_ack with event_valid = 0 has no effect.
- Simultaneous ack and flip: ack of 18'h00001 in the same cycle bit 2 flips.
  - Next event_bits = 18'h00004.
  - Repeat with the flip on bit 0 itself: event_bits stays 18'h00001.
- Async reset mid-qualification: reset asserted after 2 qualifying ticks on bit 7.
  - Outputs go 0 immediately.
  - Re-qualification needs 3 full new ticks.
